// File: rtl/dual_beam_thresh_pkg.sv
// Shared types and constants for the dual-beam threshold controller.
package dual_beam_thresh_pkg;

   localparam int THRESH_BITS     = 18;
   localparam int RATE_BITS       = 16;
   localparam int DEFAULT_PERIOD  = 375000;
   localparam int DEFAULT_HOLDOFF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      UPDATE = 2'd2,
      HOLD   = 2'd3
   } ctrlState_e;

   // The beam DSPs compare against a negated threshold.
   // Zero stays zero because the result wraps modulo 2^THRESH_BITS.
   function automatic logic [THRESH_BITS-1:0] negateThresh(input logic [THRESH_BITS-1:0] mag);
      return ~mag + THRESH_BITS'(1);
   endfunction

endpackage

// File: rtl/trig_rate_counter.sv
// Per-beam trigger counter.
// The counter is masked and saturating. Its value is captured at each window end.
module trig_rate_counter
   import dual_beam_thresh_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 trig,
   input  logic                 mask,
   input  logic                 windowEnd,
   output logic [RATE_BITS-1:0] captured
);

   logic [RATE_BITS-1:0] count;
   logic [RATE_BITS-1:0] countInc;

   // Next count: add one unmasked trigger, pinned at all-ones once saturated.
   always_comb begin
      countInc = count;
      if (!(&count)) begin
         countInc = count + RATE_BITS'(trig & ~mask);
      end
   end

   // The trigger arriving in the terminal cycle is included in the value captured for the closing window.
   // The running count then restarts from zero.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count    <= '0;
         captured <= '0;
      end else if (windowEnd) begin
         count    <= '0;
         captured <= countInc;
      end else begin
         count    <= countInc;
      end
   end

endmodule

// File: rtl/dual_beam_thresh_ctrl.sv
// Dual-beam threshold write sequencer with per-beam trigger rate measurement.
// A write loads the negated threshold, pulses the per-beam CE, commits with update_o,
// then blanks triggers for HOLDOFF cycles (HOLDOFF >= 1).
module dual_beam_thresh_ctrl
   import dual_beam_thresh_pkg::*;
#(
   parameter int PERIOD  = DEFAULT_PERIOD,
   parameter int HOLDOFF = DEFAULT_HOLDOFF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             trigger_i,
   input  logic                   wr_valid_i,
   output logic                   wr_ready_o,
   input  logic [1:0]             wr_sel_i,
   input  logic [THRESH_BITS-1:0] wr_thresh_i,
   output logic [THRESH_BITS-1:0] thresh_o,
   output logic [1:0]             thresh_ce_o,
   output logic                   update_o,
   output logic [2*RATE_BITS-1:0] rate_o,
   output logic                   rate_valid_o
);

   localparam int               WIN_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(PERIOD - 1);
   localparam int               HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

   ctrlState_e           state, stateNext;
   logic [1:0]           trigReg;
   logic [1:0]           selReg;
   logic [HOLD_W-1:0]    holdCnt;
   logic                 accept;
   logic                 blank;
   logic [WIN_W-1:0]     winCnt;
   logic                 windowEnd;
   logic [RATE_BITS-1:0] rateA, rateB;

   // Register the raw beam triggers once before they are counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) trigReg <= '0;
      else       trigReg <= trigger_i;
   end

   // FSM state register. The asynchronous reset drops the CE and update outputs at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state and Moore outputs of the write sequencer.
   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      stateNext   = state;
      wr_ready_o  = 1'b0;
      accept      = 1'b0;
      thresh_ce_o = 2'b00;
      update_o    = 1'b0;
      unique case (state)
         IDLE: begin
            wr_ready_o = !rst_i;
            accept     = wr_valid_i && !rst_i;
            if (accept) stateNext = LOAD;
         end
         LOAD: begin
            thresh_ce_o = selReg;
            stateNext   = UPDATE;
         end
         UPDATE: begin
            update_o  = |selReg;
            stateNext = HOLD;
         end
         HOLD: begin
            if (holdCnt == HOLD_LAST) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Capture the write on acceptance. Count the cycles spent in HOLD.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         thresh_o <= '0;
         selReg   <= '0;
         holdCnt  <= '0;
      end else begin
         if (accept) begin
            thresh_o <= negateThresh(wr_thresh_i);
            selReg   <= wr_sel_i;
         end
         if (state == HOLD) holdCnt <= holdCnt + HOLD_W'(1);
         else               holdCnt <= '0;
      end
   end

   // Blanking starts on the acceptance cycle and runs through HOLD.
   // That covers 3 + HOLDOFF cycles per write.
   assign blank = accept || (state != IDLE);

   // The free-running window counter. It is independent of the write sequencer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)          winCnt <= '0;
      else if (windowEnd) winCnt <= '0;
      else                winCnt <= winCnt + WIN_W'(1);
   end

   assign windowEnd = (winCnt == WIN_LAST);

   // rate_o is refreshed the cycle after the terminal count. Flag that cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rate_valid_o <= 1'b0;
      else       rate_valid_o <= windowEnd;
   end

   trig_rate_counter uBeamA (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .trig      (trigReg[0]),
      .mask      (blank),
      .windowEnd (windowEnd),
      .captured  (rateA)
   );

   trig_rate_counter uBeamB (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .trig      (trigReg[1]),
      .mask      (blank),
      .windowEnd (windowEnd),
      .captured  (rateB)
   );

   assign rate_o = {rateB, rateA};

endmodule

// File: doc/dual_beam_thresh_ctrl.md
DUAL_BEAM_THRESH_CTRL -- requirements
Module: dual_beam_thresh_ctrl

Interface
REQ-001 The block SHALL have parameter PERIOD, default 375000, giving the rate-window length in clk_i cycles (1 ms at 375 MHz).
REQ-002 The block SHALL have parameter HOLDOFF, default 8, giving the number of cycles triggers are masked after an update.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is in this domain.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port trigger_i, input, 2 bits: per-beam trigger from the dual-beam threshold stage.
REQ-006 The block SHALL have port wr_valid_i, input, 1 bit: threshold write request.
REQ-007 The block SHALL have port wr_ready_o, output, 1 bit: the block accepts a write request this cycle.
REQ-008 The block SHALL have port wr_sel_i, input, 2 bits: beam mask for the write (bit0 = beam A, bit1 = beam B).
REQ-009 The block SHALL have port wr_thresh_i, input, 18 bits: unsigned threshold magnitude.
REQ-010 The block SHALL have port thresh_o, output, 18 bits: two's-complement threshold to the beam DSPs.
REQ-011 The block SHALL have port thresh_ce_o, output, 2 bits: per-beam threshold load enable.
REQ-012 The block SHALL have port update_o, output, 1 bit: commits the loaded thresholds.
REQ-013 The block SHALL have port rate_o, output, 32 bits: {beam B count[15:0], beam A count[15:0]} for the last completed window.
REQ-014 The block SHALL have port rate_valid_o, output, 1 bit: one-cycle pulse when rate_o is refreshed.

Function
REQ-015 The block SHALL register trigger_i once before any use.
REQ-016 The FSM SHALL have states IDLE, LOAD, UPDATE and HOLD.
REQ-017 wr_ready_o SHALL equal (state==IDLE) AND NOT rst_i.
REQ-018 A write SHALL be accepted on the cycle wr_valid_i and wr_ready_o are both high; IDLE->LOAD.
REQ-019 On acceptance, thresh_o SHALL register (2^18 - wr_thresh_i) mod 2^18, so wr_thresh_i=0 gives 0.
REQ-020 In LOAD (acceptance+1), thresh_ce_o SHALL equal the captured wr_sel_i for exactly one cycle; LOAD->UPDATE.
REQ-021 In UPDATE (acceptance+2), update_o SHALL be high for exactly one cycle, unless the captured mask was 2'b00; UPDATE->HOLD.
REQ-022 HOLD SHALL last exactly HOLDOFF cycles; HOLD->IDLE, and wr_ready_o SHALL rise at acceptance+3+HOLDOFF.
REQ-023 thresh_o SHALL hold its last value outside LOAD.
REQ-024 Registered triggers SHALL be masked (not counted) in LOAD, UPDATE and HOLD.
REQ-025 The window counter SHALL run continuously, independent of the FSM, and wrap from PERIOD-1 to 0.
REQ-026 At the terminal count, a trigger present in that cycle SHALL count into the closing window.
REQ-027 One cycle after the terminal count, rate_o SHALL be loaded and rate_valid_o SHALL pulse.
REQ-028 Per-beam counters SHALL restart at 0 (plus any trigger in that same cycle) after the terminal count.
REQ-029 Per-beam counters SHALL saturate at 16'hFFFF and never wrap.
REQ-030 wr_valid_i while not ready SHALL be ignored; the requester holds it, and no queueing is performed.

Reset
REQ-031 While rst_i is high: state=IDLE, thresh_o=0, thresh_ce_o=0, update_o=0, rate_o=0, rate_valid_o=0, all counters=0, wr_ready_o=0.
REQ-032 Reset asserted mid-sequence SHALL abort it immediately with no further CE or update pulse.
REQ-033 The first window after reset deassertion SHALL be a full PERIOD cycles.

Structure
REQ-034 Package dual_beam_thresh_pkg SHALL hold the FSM state typedef, THRESH_BITS=18, RATE_BITS=16 and the PERIOD/HOLDOFF defaults.
REQ-035 One sub-module, trig_rate_counter, SHALL implement the masked, saturating per-beam counter plus capture, instantiated once per beam.

Verification
REQ-036 Scenario: PERIOD=100, trigger_i=2'b01 every cycle, no writes -> rate_o=32'h0000_0064 each window, with rate_valid_o every 100 cycles.
REQ-037 Scenario: write wr_thresh_i=18'd1000, wr_sel_i=2'b10 accepted at cycle N -> thresh_o=18'h3FC18, thresh_ce_o=2'b10 at N+1, update_o at N+2, wr_ready_o high at N+11 (HOLDOFF=8).
REQ-038 Scenario: trigger_i=2'b11 constant across a write sequence, PERIOD=100 -> both counts=89 (100-11 masked cycles) in that window.
REQ-039 Scenario: PERIOD=70000, trigger_i=2'b11 constant -> both counts=16'hFFFF.
REQ-040 Scenario: wr_sel_i=2'b00 write -> no thresh_ce_o, no update_o; wr_ready_o returns after 3+HOLDOFF cycles.
REQ-041 Scenario: rst_i asserted in LOAD -> outputs zero immediately, no update_o; after release, thresh_o=0 and wr_ready_o=1.
